// File: rtl/imsic_intp_file.sv
// imsic_intp_file: one IMSIC interrupt file with ingress FIFO, eip/eie arrays and a sequential topei sweep
module imsic_intp_file #(
  parameter int NrSources  = 64,
  parameter int NrSourcesW = $clog2(NrSources),
  parameter int FifoDepth  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NrSourcesW-1:0] i_setipnum,
  input  logic                  i_setipnum_we,
  input  logic                  i_eidelivery,
  input  logic [NrSourcesW-1:0] i_eithreshold,
  input  logic                  i_eie_we,
  input  logic [NrSourcesW-1:0] i_eie_id,
  input  logic                  i_eie_val,
  input  logic                  i_claim,
  output logic [NrSourcesW-1:0] o_topei,
  output logic                  o_irq,
  output logic [NrSources-1:0]  o_eip,
  output logic [NrSources-1:0]  o_eie,
  output logic                  o_overflow
);
  localparam int PtrW = $clog2(FifoDepth);
  localparam int PW   = PtrW + 1;
  typedef enum logic {IDLE, SCAN} state_e;
  state_e                state_q, state_d;
  logic [NrSourcesW-1:0] fifo_q [FifoDepth];
  logic [NrSourcesW-1:0] fifo_d [FifoDepth];
  logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic                  pop_v_q, pop_v_d;
  logic [NrSourcesW-1:0] pop_id_q, pop_id_d;
  logic [NrSources-1:0]  eip_q, eip_d, eie_q, eie_d;
  logic [NrSourcesW-1:0] thr_q, thr_d;
  logic                  ovf_q, ovf_d;
  logic                  dirty_q, dirty_d;
  logic [NrSourcesW-1:0] idx_q, idx_d, best_q, best_d, topei_q, topei_d;
  logic                  empty, full, claim_go, pop_go, fifo_pop, push_ok, pop_ok, change, elig, last;
  // The head of the FIFO is staged in pop_id_q; a claim strobe owns the eip write port that cycle.
  always_comb begin
    empty    = wr_q == rd_q;
    full     = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
    claim_go = i_claim && (topei_q != '0);
    pop_go   = pop_v_q && !i_claim;
    fifo_pop = !empty && (!pop_v_q || pop_go);
    push_ok  = i_setipnum_we && (!full || fifo_pop);
    pop_ok   = (pop_id_q != '0) && (int'(pop_id_q) < NrSources);
    fifo_d   = fifo_q;
    if (push_ok) fifo_d[wr_q[PtrW-1:0]] = i_setipnum;
    wr_d     = wr_q + PW'(push_ok);
    rd_d     = rd_q + PW'(fifo_pop);
    pop_v_d  = fifo_pop || (pop_v_q && !pop_go);
    pop_id_d = fifo_pop ? fifo_q[rd_q[PtrW-1:0]] : pop_id_q;
    eip_d    = eip_q;
    if (claim_go) eip_d[topei_q] = 1'b0;
    else if (pop_go && pop_ok) eip_d[pop_id_q] = 1'b1;
    eie_d    = eie_q;
    if (i_eie_we && (i_eie_id != '0)) eie_d[i_eie_id] = i_eie_val;
    ovf_d    = ovf_q || (i_setipnum_we && !push_ok);
    thr_d    = i_eithreshold;
    change   = (eip_d != eip_q) || (eie_d != eie_q) || (i_eithreshold != thr_q) || claim_go;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fifo_q   <= '{default: '0};
      wr_q     <= '0;
      rd_q     <= '0;
      pop_v_q  <= 1'b0;
      pop_id_q <= '0;
      eip_q    <= '0;
      eie_q    <= '0;
      thr_q    <= '0;
      ovf_q    <= 1'b0;
      dirty_q  <= 1'b0;
      idx_q    <= '0;
      best_q   <= '0;
      topei_q  <= '0;
    end else begin
      fifo_q   <= fifo_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      pop_v_q  <= pop_v_d;
      pop_id_q <= pop_id_d;
      eip_q    <= eip_d;
      eie_q    <= eie_d;
      thr_q    <= thr_d;
      ovf_q    <= ovf_d;
      dirty_q  <= dirty_d;
      idx_q    <= idx_d;
      best_q   <= best_d;
      topei_q  <= topei_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // A pending dirty flag restarts the sweep from id 1 whether idle or mid-scan.
  always_comb begin
    elig    = eip_q[idx_q] && eie_q[idx_q] && ((i_eithreshold == '0) || (idx_q < i_eithreshold));
    last    = idx_q == NrSourcesW'(NrSources - 1);
    state_d = state_q;
    idx_d   = idx_q;
    best_d  = best_q;
    topei_d = topei_q;
    dirty_d = dirty_q || change;
    if (dirty_q) begin
      state_d = SCAN;
      idx_d   = NrSourcesW'(1);
      best_d  = '0;
      dirty_d = change;
    end else if (state_q == SCAN) begin
      best_d  = (elig && (best_q == '0)) ? idx_q : best_q;
      idx_d   = last ? idx_q : idx_q + NrSourcesW'(1);
      state_d = last ? IDLE : SCAN;
      topei_d = last ? ((best_q != '0) ? best_q : (elig ? idx_q : '0)) : topei_q;
    end
    if (claim_go) topei_d = '0;
  end
  always_comb begin
    o_topei    = topei_q;
    o_irq      = i_eidelivery && (topei_q != '0);
    o_eip      = eip_q;
    o_eie      = eie_q;
    o_overflow = ovf_q;
  end
endmodule

// File: tb/tb_imsic_intp_file.sv
// tb_imsic_intp_file: directed checks of ingress, claim, threshold, overflow and sweep timing
module tb_imsic_intp_file;
  localparam int N  = 64;
  localparam int W  = 6;
  localparam int SETTLE = 2 * N + 12;
  logic         i_clk = 1'b0;
  logic         i_rst = 1'b0;
  logic [W-1:0] i_setipnum = '0;
  logic         i_setipnum_we = 1'b0;
  logic         i_eidelivery = 1'b1;
  logic [W-1:0] i_eithreshold = '0;
  logic         i_eie_we = 1'b0;
  logic [W-1:0] i_eie_id = '0;
  logic         i_eie_val = 1'b0;
  logic         i_claim = 1'b0;
  logic [W-1:0] o_topei;
  logic         o_irq;
  logic [N-1:0] o_eip;
  logic [N-1:0] o_eie;
  logic         o_overflow;
  int           n_tests = 0;
  int           n_fail = 0;
  imsic_intp_file #(.NrSources(N), .NrSourcesW(W), .FifoDepth(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_setipnum(i_setipnum), .i_setipnum_we(i_setipnum_we),
    .i_eidelivery(i_eidelivery), .i_eithreshold(i_eithreshold), .i_eie_we(i_eie_we),
    .i_eie_id(i_eie_id), .i_eie_val(i_eie_val), .i_claim(i_claim), .o_topei(o_topei),
    .o_irq(o_irq), .o_eip(o_eip), .o_eie(o_eie), .o_overflow(o_overflow)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask
  task automatic do_reset();
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    chk("rst_topei", 64'(o_topei), 64'd0);
    chk("rst_irq", 64'(o_irq), 64'd0);
    chk("rst_eip", o_eip, 64'd0);
    chk("rst_eie", o_eie, 64'd0);
    chk("rst_ovf", 64'(o_overflow), 64'd0);
  endtask
  task automatic setip(input int id);
    i_setipnum = W'(id);
    i_setipnum_we = 1'b1;
    tick(1);
    i_setipnum_we = 1'b0;
  endtask
  task automatic set_eie(input int id, input logic v);
    i_eie_id = W'(id);
    i_eie_val = v;
    i_eie_we = 1'b1;
    tick(1);
    i_eie_we = 1'b0;
  endtask
  task automatic claim();
    i_claim = 1'b1;
    tick(1);
    i_claim = 1'b0;
  endtask
  initial begin
    do_reset();
    // latency and exact sweep timing for a single source
    set_eie(5, 1'b1);
    chk("eie5", o_eie, 64'h20);
    setip(5);
    chk("lat_e0", o_eip, 64'd0);
    tick(1);
    chk("lat_e1", o_eip, 64'd0);
    tick(1);
    chk("lat_e2", o_eip, 64'h20);
    tick(63);
    chk("sweep_early", 64'(o_topei), 64'd0);
    tick(1);
    chk("sweep_done", 64'(o_topei), 64'd5);
    chk("irq_on", 64'(o_irq), 64'd1);
    i_eidelivery = 1'b0;
    #1;
    chk("irq_off", 64'(o_irq), 64'd0);
    i_eidelivery = 1'b1;
    // priority and claim sequence
    do_reset();
    set_eie(9, 1'b1);
    set_eie(3, 1'b1);
    set_eie(40, 1'b1);
    setip(9);
    setip(3);
    setip(40);
    tick(SETTLE);
    chk("prio_3", 64'(o_topei), 64'd3);
    claim();
    chk("claim_top0", 64'(o_topei), 64'd0);
    chk("claim_eip", o_eip, (64'd1 << 9) | (64'd1 << 40));
    tick(SETTLE);
    chk("prio_9", 64'(o_topei), 64'd9);
    claim();
    tick(SETTLE);
    chk("prio_40", 64'(o_topei), 64'd40);
    chk("eip_40", o_eip, 64'd1 << 40);
    // threshold
    do_reset();
    i_eithreshold = W'(8);
    set_eie(9, 1'b1);
    set_eie(12, 1'b1);
    setip(9);
    setip(12);
    tick(SETTLE);
    chk("thr8_top", 64'(o_topei), 64'd0);
    chk("thr8_irq", 64'(o_irq), 64'd0);
    i_eithreshold = W'(10);
    tick(SETTLE);
    chk("thr10_top", 64'(o_topei), 64'd9);
    i_eithreshold = '0;
    // reserved and out-of-range identities
    do_reset();
    setip(0);
    setip(64);
    tick(6);
    chk("id0_eip", o_eip, 64'd0);
    chk("id0_ovf", 64'(o_overflow), 64'd0);
    // overflow with pops stalled by a held claim strobe
    do_reset();
    i_claim = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      i_setipnum = W'(i);
      i_setipnum_we = 1'b1;
      tick(1);
      if (i == 5) chk("ovf_before", 64'(o_overflow), 64'd0);
    end
    i_setipnum_we = 1'b0;
    chk("ovf_set", 64'(o_overflow), 64'd1);
    i_claim = 1'b0;
    tick(10);
    chk("ovf_eip", o_eip, 64'h3E);
    chk("ovf_sticky", 64'(o_overflow), 64'd1);
    // claim colliding with a re-set of the same identity
    do_reset();
    set_eie(7, 1'b1);
    setip(7);
    tick(SETTLE);
    chk("col_top7", 64'(o_topei), 64'd7);
    setip(7);
    tick(1);
    claim();
    chk("col_top0", 64'(o_topei), 64'd0);
    chk("col_eip0", o_eip, 64'd0);
    tick(1);
    chk("col_eip1", o_eip, 64'h80);
    tick(SETTLE);
    chk("col_top7b", 64'(o_topei), 64'd7);
    // reset in the middle of a sweep
    set_eie(20, 1'b1);
    setip(20);
    tick(12);
    do_reset();
    tick(SETTLE);
    chk("post_rst_top", 64'(o_topei), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
